piso_ser: RTL and testbench

Parallel-in serial-out transmitter that feeds the serial input of the 4-bit SIPO shift register. It accepts a WIDTH-bit word over a valid/ready handshake, buffers one pending word, and shifts each word out one bit per clock with a bit-valid and start-of-frame strobe. An optional idle gap separates frames. Back-to-back words stream without bubbles when GAP=0.

---
 rtl/piso_pkg.sv | 21 ++
 rtl/piso_ser_if.sv | 26 ++
 rtl/piso_hold.sv | 52 +++++
 rtl/piso_ser.sv | 152 +++++++++++++++
 tb/tb_piso_ser.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the piso_ser parallel-in serial-out transmitter.
//   - state_e      : FSM state encoding (IDLE / SHIFT / GAP)
//   - GAP_CNT_W    : width of the inter-frame gap counter
//   - bit_cnt_w()  : bit-counter width for a given word width
package piso_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam int DEF_WIDTH     = 4;
  localparam int GAP_CNT_W     = 4;
  localparam int DEF_BIT_CNT_W = $clog2(DEF_WIDTH);

  function automatic int bit_cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_ser_if.sv
// Bus interface of piso_ser.
//   pi / pi_valid / pi_ready : parallel word handshake (source -> transmitter)
//   so / so_en / sof         : serial bit, bit-valid and start-of-frame strobes
//   busy                     : frame in progress, in gap, or word pending
// master = word source / serial sink, slave = the transmitter.
interface piso_ser_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] pi;
  logic             pi_valid;
  logic             pi_ready;
  logic             so;
  logic             so_en;
  logic             sof;
  logic             busy;

  modport master (
    output pi, pi_valid,
    input  pi_ready, so, so_en, sof, busy
  );

  modport slave (
    input  pi, pi_valid,
    output pi_ready, so, so_en, sof, busy
  );
endinterface

// File: rtl/piso_hold.sv
// One-entry pending-word buffer for piso_ser.
// Ports:
//   clk, clr_n   : clock, synchronous active-low reset
//   pi, pi_valid : incoming word and its valid
//   pi_ready     : out, buffer can take a word (empty and not in reset)
//   take_direct  : in, a transfer this edge goes straight into the shifter
//   unload       : in, shifter consumes the held word this edge
//   xfer         : out, handshake completes this edge
//   hold_data    : out, buffered word
//   hold_full    : out, buffer occupied
module piso_hold #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] pi,
  input  logic             pi_valid,
  output logic             pi_ready,
  input  logic             take_direct,
  input  logic             unload,
  output logic             xfer,
  output logic [WIDTH-1:0] hold_data,
  output logic             hold_full
);

  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             load;

  // Ready never depends on the unload of the same edge, so a transfer and
  // an unload can never coincide.
  assign pi_ready = ~hold_full_q & clr_n;
  assign xfer     = pi_valid & pi_ready;

  always_comb begin
    load        = xfer & ~take_direct;
    hold_d      = load ? pi : hold_q;
    hold_full_d = hold_full_q;
    if (unload) hold_full_d = 1'b0;
    if (load)   hold_full_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!clr_n) hold_full_q <= 1'b0;
    else        hold_full_q <= hold_full_d;
    hold_q <= hold_d;
  end

  assign hold_data = hold_q;
  assign hold_full = hold_full_q;

endmodule

// File: rtl/piso_ser.sv
// Parallel-in serial-out transmitter feeding a SIPO serial input.
// Accepts a WIDTH-bit word over a valid/ready handshake, buffers one pending
// word and shifts each word out one bit per clock, optionally followed by
// GAP idle cycles. With GAP=0 consecutive words stream without bubbles.
// Ports:
//   clk   : rising-edge clock
//   clr_n : synchronous active-low reset
//   bus   : piso_ser_if slave (pi/pi_valid/pi_ready, so/so_en/sof, busy)
module piso_ser
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1,
  parameter int GAP       = 0
) (
  input  logic       clk,
  input  logic       clr_n,
  piso_ser_if.slave  bus
);

  localparam int                  CNT_W    = bit_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0]    LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = (GAP > 0) ? GAP_CNT_W'(GAP - 1) : '0;

  function automatic logic out_bit(input logic [WIDTH-1:0] s);
    return (MSB_FIRST != 0) ? s[WIDTH-1] : s[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_next(input logic [WIDTH-1:0] s);
    return (MSB_FIRST != 0) ? {s[WIDTH-2:0], 1'b0} : {1'b0, s[WIDTH-1:1]};
  endfunction

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [GAP_CNT_W-1:0]  gap_q, gap_d;
  logic                  so_q, so_d;
  logic                  so_en_q, so_en_d;
  logic                  sof_q, sof_d;

  logic                  xfer, hold_full, take_direct, unload;
  logic [WIDTH-1:0]      hold_data;
  logic                  last_bit, gap_done, frame_end;
  logic                  load_pi, shift_en;

  // frame_end marks an edge at which the next frame may begin: the last bit
  // when there is no gap, or the final gap cycle. A pending word wins over a
  // fresh transfer; a fresh transfer only goes direct when hold is empty.
  assign last_bit    = (state_q == ST_SHIFT) && (cnt_q == LAST_BIT);
  assign gap_done    = (state_q == ST_GAP) && (gap_q == GAP_LAST);
  assign frame_end   = (last_bit && (GAP == 0)) || gap_done;
  assign unload      = frame_end & hold_full;
  assign take_direct = (state_q == ST_IDLE) | (frame_end & ~hold_full);

  piso_hold #(.WIDTH(WIDTH)) u_hold (
    .clk         (clk),
    .clr_n       (clr_n),
    .pi          (bus.pi),
    .pi_valid    (bus.pi_valid),
    .pi_ready    (bus.pi_ready),
    .take_direct (take_direct),
    .unload      (unload),
    .xfer        (xfer),
    .hold_data   (hold_data),
    .hold_full   (hold_full)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      so_q    <= 1'b0;
      so_en_q <= 1'b0;
      sof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      so_q    <= so_d;
      so_en_q <= so_en_d;
      sof_q   <= sof_d;
    end
    shift_q <= shift_d;
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    load_pi  = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          load_pi = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!last_bit)    shift_en = 1'b1;
        else if (GAP > 0) state_d  = ST_GAP;
        else if (unload)  state_d  = ST_SHIFT;
        else if (xfer)    load_pi  = 1'b1;
        else              state_d  = ST_IDLE;
      end
      ST_GAP: begin
        if (gap_done) begin
          if (unload) begin
            state_d = ST_SHIFT;
          end else if (xfer) begin
            load_pi = 1'b1;
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered-output logic: outputs are computed from the
  // next shifter/counter state so they line up with the cycle they describe.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load_pi) begin
      shift_d = bus.pi;
      cnt_d   = '0;
    end else if (unload) begin
      shift_d = hold_data;
      cnt_d   = '0;
    end else if (shift_en) begin
      shift_d = shift_next(shift_q);
      cnt_d   = cnt_q + 1'b1;
    end

    if ((state_q == ST_GAP) && !gap_done) gap_d = gap_q + 1'b1;
    else                                   gap_d = '0;

    so_en_d = (state_d == ST_SHIFT);
    sof_d   = so_en_d && (cnt_d == '0);
    so_d    = so_en_d & out_bit(shift_d);
  end

  assign bus.so    = so_q;
  assign bus.so_en = so_en_q;
  assign bus.sof   = sof_q;
  assign bus.busy  = (state_q != ST_IDLE) | hold_full;

endmodule

// File: tb/tb_piso_ser.sv
// Scoreboard bench for piso_ser: three instances (MSB-first no gap,
// LSB-first no gap, MSB-first GAP=2) plus a 4-bit SIPO model on instance A.
module tb_piso_ser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  piso_ser_if #(.WIDTH(4)) if_a ();
  piso_ser_if #(.WIDTH(4)) if_b ();
  piso_ser_if #(.WIDTH(4)) if_c ();

  piso_ser #(.WIDTH(4), .MSB_FIRST(1), .GAP(0)) u_a (.clk(clk), .clr_n(clr_n), .bus(if_a.slave));
  piso_ser #(.WIDTH(4), .MSB_FIRST(0), .GAP(0)) u_b (.clk(clk), .clr_n(clr_n), .bus(if_b.slave));
  piso_ser #(.WIDTH(4), .MSB_FIRST(1), .GAP(2)) u_c (.clk(clk), .clr_n(clr_n), .bus(if_c.slave));

  logic [3:0] pi_r  [3];
  logic       vld_r [3];
  assign if_a.pi = pi_r[0];  assign if_a.pi_valid = vld_r[0];
  assign if_b.pi = pi_r[1];  assign if_b.pi_valid = vld_r[1];
  assign if_c.pi = pi_r[2];  assign if_c.pi_valid = vld_r[2];

  // Downstream 4-bit SIPO fed by instance A
  logic [3:0] po;
  always @(posedge clk) begin
    if (!clr_n)          po <= 4'b0000;
    else if (if_a.so_en) po <= {po[2:0], if_a.so};
  end

  typedef logic [1:0] exp_t;   // {so, sof}
  exp_t q_a[$], q_b[$], q_c[$];
  int   sof_cyc_c[$];
  int   run_a = 0, max_run_a = 0;
  int   nvec = 0, nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic rdy(input int sel);
    case (sel)
      0:       return if_a.pi_ready;
      1:       return if_b.pi_ready;
      default: return if_c.pi_ready;
    endcase
  endfunction

  function automatic int qsize(input int sel);
    case (sel)
      0:       return q_a.size();
      1:       return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  // bits: expected serial stream in time order, bits[3] first
  task automatic push_frame(input int sel, input logic [3:0] bits);
    exp_t e;
    for (int i = 3; i >= 0; i--) begin
      e = {bits[i], (i == 3) ? 1'b1 : 1'b0};
      case (sel)
        0:       q_a.push_back(e);
        1:       q_b.push_back(e);
        default: q_c.push_back(e);
      endcase
    end
  endtask

  task automatic send(input int sel, input logic [3:0] word, input logic [3:0] bits);
    bit done = 0;
    int t = 0;
    pi_r[sel]  = word;
    vld_r[sel] = 1'b1;
    while (!done && t < 50) begin
      @(negedge clk);
      if (rdy(sel) === 1'b1) begin
        @(posedge clk); #1;
        push_frame(sel, bits);
        done = 1;
      end else begin
        @(posedge clk); #1;
        t++;
      end
    end
    chk($sformatf("accept[%0d]", sel), 32'(done), 1);
  endtask

  task automatic drain(input int sel);
    int t = 0;
    while (qsize(sel) != 0 && t < 40) begin
      @(posedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk($sformatf("drain[%0d]", sel), qsize(sel), 0);
  endtask

  task automatic wait_sof_a(output bit found);
    found = 0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk);
      if (if_a.sof === 1'b1) found = 1;
    end
  endtask

  task automatic mon(input int sel, input logic en, input logic so, input logic sof);
    exp_t e;
    if (en !== 1'b1) return;
    chk($sformatf("bit_expected[%0d]", sel), 32'(qsize(sel) != 0), 1);
    if (qsize(sel) == 0) return;
    case (sel)
      0:       e = q_a.pop_front();
      1:       e = q_b.pop_front();
      default: e = q_c.pop_front();
    endcase
    chk($sformatf("so[%0d]", sel),  32'(so),  32'(e[1]));
    chk($sformatf("sof[%0d]", sel), 32'(sof), 32'(e[0]));
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents a valid bit
  initial begin
    forever begin
      @(negedge clk);
      mon(0, if_a.so_en, if_a.so, if_a.sof);
      mon(1, if_b.so_en, if_b.so, if_b.sof);
      mon(2, if_c.so_en, if_c.so, if_c.sof);
      if (if_c.so_en === 1'b1 && if_c.sof === 1'b1) sof_cyc_c.push_back(cyc);
      if (if_a.so_en === 1'b1) begin
        run_a++;
        if (run_a > max_run_a) max_run_a = run_a;
      end else begin
        run_a = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int d;
    clr_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pi_r[i]  = 4'b0000;
      vld_r[i] = 1'b0;
    end
    // Reset with a valid word waiting on A
    pi_r[0]  = 4'b1011;
    vld_r[0] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_so",       32'(if_a.so),       0);
    chk("rst_so_en",    32'(if_a.so_en),    0);
    chk("rst_sof",      32'(if_a.sof),      0);
    chk("rst_busy",     32'(if_a.busy),     0);
    chk("rst_pi_ready", 32'(if_a.pi_ready), 0);
    chk("rst_busy_c",   32'(if_c.busy),     0);
    @(posedge clk); #1;
    clr_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 32'(if_a.pi_ready), 1);
    @(posedge clk); #1;
    push_frame(0, 4'b1011);
    vld_r[0] = 1'b0;
    @(negedge clk);
    chk("latency_so_en", 32'(if_a.so_en), 1);
    chk("latency_sof",   32'(if_a.sof),   1);
    drain(0);
    chk("idle_busy", 32'(if_a.busy), 0);

    // Back-to-back, GAP=0
    max_run_a = 0;
    send(0, 4'b1011, 4'b1011);
    send(0, 4'b0110, 4'b0110);
    @(negedge clk);
    chk("ready_low_hold_full", 32'(if_a.pi_ready), 0);
    chk("busy_hold_full",      32'(if_a.busy),     1);
    send(0, 4'b1111, 4'b1111);
    vld_r[0] = 1'b0;
    drain(0);
    chk("b2b_run_len", max_run_a, 12);
    chk("b2b_busy",    32'(if_a.busy), 0);

    // LSB first
    send(1, 4'b0001, 4'b1000);
    vld_r[1] = 1'b0;
    drain(1);

    // GAP=2
    send(2, 4'b1010, 4'b1010);
    send(2, 4'b0101, 4'b0101);
    vld_r[2] = 1'b0;
    drain(2);
    chk("gap_frames", sof_cyc_c.size(), 2);
    d = (sof_cyc_c.size() >= 2) ? sof_cyc_c[1] - sof_cyc_c[0] : -1;
    chk("gap_period", d, 6);

    // Loopback into SIPO
    send(0, 4'b1011, 4'b1011);
    vld_r[0] = 1'b0;
    wait_sof_a(found);
    chk("loop_sof_seen", 32'(found), 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("loop_po", 32'(po), 32'(4'b1011));
    drain(0);

    // Reset mid-frame
    send(0, 4'b0110, 4'b0110);
    vld_r[0] = 1'b0;
    wait_sof_a(found);
    chk("mid_sof_seen", 32'(found), 1);
    @(posedge clk); #1;
    clr_n = 1'b0;
    @(posedge clk); #1;
    q_a.delete();
    @(negedge clk);
    chk("mid_rst_so_en",    32'(if_a.so_en),    0);
    chk("mid_rst_busy",     32'(if_a.busy),     0);
    chk("mid_rst_pi_ready", 32'(if_a.pi_ready), 0);
    @(posedge clk); #1;
    clr_n = 1'b1;
    send(0, 4'b1111, 4'b1111);
    vld_r[0] = 1'b0;
    @(negedge clk);
    chk("restart_sof", 32'(if_a.sof), 1);
    drain(0);

    chk("final_q_a", q_a.size(), 0);
    chk("final_q_b", q_b.size(), 0);
    chk("final_q_c", q_c.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
